// File: rtl/weight_ctrl_pkg.sv
// Shared types and sizing helpers for the weight load/compute sequencer.
package weight_ctrl_pkg;

  localparam int unsigned MAX_MEM_LAT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_LOADED,
    ST_RUN
  } wctl_state_t;

  // Columns per bank: how many column groups of width P cover N columns.
  function automatic int unsigned cpb(input int unsigned n, input int unsigned p);
    return (n + p - 1) / p;
  endfunction

  function automatic int unsigned bank_aw(input int unsigned n, input int unsigned p);
    return (n * cpb(n, p) > 1) ? $clog2(n * cpb(n, p)) : 1;
  endfunction

endpackage

// File: rtl/weight_load_ctrl_tag_delay.sv
// Fixed-depth shift register that carries a request tag until its memory data returns.
module tag_delay #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] tag_i,
  output logic [WIDTH-1:0] tag_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int unsigned i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/weight_load_ctrl.sv
// Loads an N x N weight matrix from main memory into P column-interleaved banks,
// then sweeps the bank read port once per start request.
module weight_load_ctrl
  import weight_ctrl_pkg::*;
#(
  parameter  int unsigned FEATURE_BITS = 4,
  parameter  int unsigned N_FEATURES   = 9,
  parameter  int unsigned ELEMENT_BITS = 8,
  parameter  int unsigned P            = 4,
  parameter  int unsigned MEM_LAT      = 1,
  localparam int unsigned BANK_AW      = bank_aw(N_FEATURES, P),
  localparam int unsigned BANK_BW      = (P > 1) ? $clog2(P) : 1
) (
  input  logic                      sys_clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic                      start,
  input  logic [ELEMENT_BITS-1:0]   main_mem_data,
  output logic [2*FEATURE_BITS-1:0] main_mem_address,
  output logic                      main_mem_cs_out,
  output logic                      main_mem_oe_out,
  output logic                      wr_en,
  output logic [BANK_BW-1:0]        wr_bank,
  output logic [BANK_AW-1:0]        wr_addr,
  output logic [ELEMENT_BITS-1:0]   wr_data,
  output logic                      rd_en,
  output logic [BANK_AW-1:0]        rd_addr,
  output logic                      pe_valid,
  output logic                      load_done,
  output logic                      compute_done,
  output logic                      busy
);

  localparam int unsigned CPB   = cpb(N_FEATURES, P);
  localparam int unsigned TAG_W = 1 + BANK_BW + BANK_AW;

  localparam logic [FEATURE_BITS-1:0] LAST_IDX      = FEATURE_BITS'(N_FEATURES - 1);
  localparam logic [BANK_BW-1:0]      LAST_BANK     = BANK_BW'(P - 1);
  localparam logic [BANK_BW-1:0]      FINAL_WR_BANK = BANK_BW'((N_FEATURES - 1) % P);
  localparam logic [BANK_AW-1:0]      FINAL_WR_ADDR = BANK_AW'((N_FEATURES - 1) * CPB + (N_FEATURES - 1) / P);
  localparam logic [BANK_AW-1:0]      LAST_RD_ADDR  = BANK_AW'(N_FEATURES * CPB - 1);
  localparam logic [BANK_AW-1:0]      CPB_STEP      = BANK_AW'(CPB);

  wctl_state_t state_q, state_d;
  logic [FEATURE_BITS-1:0] row_q, row_d, col_q, col_d;
  logic [BANK_BW-1:0]      bank_q, bank_d;
  logic [BANK_AW-1:0]      grp_q, grp_d, rbase_q, rbase_d, rcnt_q, rcnt_d;
  logic                    cs, rd_en_c, load_done_d, last_wr;
  logic [TAG_W-1:0]        tag_in, tag_out;

  logic                    wr_en_q, pe_valid_q, load_done_q, compute_done_q;
  logic [BANK_BW-1:0]      wr_bank_q;
  logic [BANK_AW-1:0]      wr_addr_q;
  logic [ELEMENT_BITS-1:0] wr_data_q;

  assign last_wr = wr_en_q && (wr_bank_q == FINAL_WR_BANK) && (wr_addr_q == FINAL_WR_ADDR);

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    bank_d      = bank_q;
    grp_d       = grp_q;
    rbase_d     = rbase_q;
    rcnt_d      = rcnt_q;
    cs          = 1'b0;
    rd_en_c     = 1'b0;
    load_done_d = 1'b0;
    unique case (state_q)
      ST_IDLE: if (load) state_d = ST_LOAD;
      ST_LOAD: begin
        cs = 1'b1;
        // Bank and group track col mod P and col / P without a divider.
        if (col_q == LAST_IDX) begin
          col_d   = '0;
          bank_d  = '0;
          grp_d   = '0;
          row_d   = row_q + 1'b1;
          rbase_d = rbase_q + CPB_STEP;
          if (row_q == LAST_IDX) begin
            row_d   = '0;
            rbase_d = '0;
            state_d = ST_DRAIN;
          end
        end else begin
          col_d = col_q + 1'b1;
          if (bank_q == LAST_BANK) begin
            bank_d = '0;
            grp_d  = grp_q + 1'b1;
          end else begin
            bank_d = bank_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (last_wr) begin
          state_d     = ST_LOADED;
          load_done_d = 1'b1;
        end
      end
      ST_LOADED: begin
        if (load)       state_d = ST_LOAD;
        else if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        rd_en_c = 1'b1;
        if (rcnt_q == LAST_RD_ADDR) begin
          rcnt_d  = '0;
          state_d = ST_LOADED;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      bank_q  <= '0;
      grp_q   <= '0;
      rbase_q <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      bank_q  <= bank_d;
      grp_q   <= grp_d;
      rbase_q <= rbase_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign tag_in = {cs, bank_q, rbase_q + grp_q};

  tag_delay #(
    .WIDTH (TAG_W),
    .DEPTH (MEM_LAT)
  ) u_tag_delay (
    .clk_i (sys_clk),
    .rst_i (reset),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      wr_en_q        <= 1'b0;
      wr_bank_q      <= '0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      pe_valid_q     <= 1'b0;
      load_done_q    <= 1'b0;
      compute_done_q <= 1'b0;
    end else begin
      wr_en_q <= tag_out[TAG_W-1];
      if (tag_out[TAG_W-1]) begin
        wr_bank_q <= tag_out[BANK_AW +: BANK_BW];
        wr_addr_q <= tag_out[BANK_AW-1:0];
        wr_data_q <= main_mem_data;
      end
      pe_valid_q     <= rd_en_c;
      load_done_q    <= load_done_d;
      compute_done_q <= rd_en_c && (rcnt_q == LAST_RD_ADDR);
    end
  end

  assign main_mem_address = {row_q, col_q};
  assign main_mem_cs_out  = cs;
  assign main_mem_oe_out  = cs;
  assign wr_en            = wr_en_q;
  assign wr_bank          = wr_bank_q;
  assign wr_addr          = wr_addr_q;
  assign wr_data          = wr_data_q;
  assign rd_en            = rd_en_c;
  assign rd_addr          = rcnt_q;
  assign pe_valid         = pe_valid_q;
  assign load_done        = load_done_q;
  assign compute_done     = compute_done_q;
  assign busy             = (state_q == ST_LOAD) || (state_q == ST_DRAIN) || (state_q == ST_RUN);

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Directed bench: instance 0 uses MEM_LAT=1, instance 1 uses MEM_LAT=3; memory returns 9*row+col.
module tb_weight_load_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       load [2];
  logic       start [2];
  logic [7:0] mdata [2];
  logic [7:0] addr [2];
  logic [7:0] wr_data [2];
  logic       cs [2];
  logic       oe [2];
  logic       wr_en [2];
  logic       rd_en [2];
  logic       pe_valid [2];
  logic       load_done [2];
  logic       compute_done [2];
  logic       busy [2];
  logic [1:0] wr_bank [2];
  logic [4:0] wr_addr [2];
  logic [4:0] rd_addr [2];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  weight_load_ctrl #(.MEM_LAT(1)) dut1 (
    .sys_clk(clk), .reset(reset), .load(load[0]), .start(start[0]),
    .main_mem_data(mdata[0]), .main_mem_address(addr[0]),
    .main_mem_cs_out(cs[0]), .main_mem_oe_out(oe[0]),
    .wr_en(wr_en[0]), .wr_bank(wr_bank[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
    .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .pe_valid(pe_valid[0]),
    .load_done(load_done[0]), .compute_done(compute_done[0]), .busy(busy[0])
  );

  weight_load_ctrl #(.MEM_LAT(3)) dut3 (
    .sys_clk(clk), .reset(reset), .load(load[1]), .start(start[1]),
    .main_mem_data(mdata[1]), .main_mem_address(addr[1]),
    .main_mem_cs_out(cs[1]), .main_mem_oe_out(oe[1]),
    .wr_en(wr_en[1]), .wr_bank(wr_bank[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
    .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .pe_valid(pe_valid[1]),
    .load_done(load_done[1]), .compute_done(compute_done[1]), .busy(busy[1])
  );

  // Main memory model: read data 9*row+col, delivered through a latency pipe.
  logic [7:0] mp [2][3];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      mp[k][0] <= cs[k] ? 8'(9 * int'(addr[k][7:4]) + int'(addr[k][3:0])) : 8'hEE;
      mp[k][1] <= mp[k][0];
      mp[k][2] <= mp[k][1];
    end
  end
  assign mdata[0] = mp[0][0];
  assign mdata[1] = mp[1][2];

  // Event logs, appended on the falling edge.
  int         n_cs [2], n_wr [2], n_rd [2], n_pv [2], n_ld [2], n_cd [2];
  int         cs_cyc [2][1024];
  logic [7:0] cs_adr [2][1024];
  int         wr_cyc [2][1024];
  logic [1:0] wr_bk [2][1024];
  logic [4:0] wr_ad [2][1024];
  logic [7:0] wr_dt [2][1024];
  logic       wr_busy [2][1024];
  int         rd_cyc [2][1024];
  logic [4:0] rd_ad [2][1024];
  int         pv_cyc [2][1024];
  int         ld_cyc [2][64];
  logic       ld_busy [2][64];
  int         cd_cyc [2][64];
  int         b_cs [2], b_wr [2], b_rd [2], b_pv [2], b_ld [2], b_cd [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (cs[k] && n_cs[k] < 1024) begin
        cs_cyc[k][n_cs[k]] = cyc;
        cs_adr[k][n_cs[k]] = addr[k];
      end
      if (cs[k]) n_cs[k]++;
      if (wr_en[k] && n_wr[k] < 1024) begin
        wr_cyc[k][n_wr[k]]  = cyc;
        wr_bk[k][n_wr[k]]   = wr_bank[k];
        wr_ad[k][n_wr[k]]   = wr_addr[k];
        wr_dt[k][n_wr[k]]   = wr_data[k];
        wr_busy[k][n_wr[k]] = busy[k];
      end
      if (wr_en[k]) n_wr[k]++;
      if (rd_en[k] && n_rd[k] < 1024) begin
        rd_cyc[k][n_rd[k]] = cyc;
        rd_ad[k][n_rd[k]]  = rd_addr[k];
      end
      if (rd_en[k]) n_rd[k]++;
      if (pe_valid[k] && n_pv[k] < 1024) pv_cyc[k][n_pv[k]] = cyc;
      if (pe_valid[k]) n_pv[k]++;
      if (load_done[k] && n_ld[k] < 64) begin
        ld_cyc[k][n_ld[k]]  = cyc;
        ld_busy[k][n_ld[k]] = busy[k];
      end
      if (load_done[k]) n_ld[k]++;
      if (compute_done[k] && n_cd[k] < 64) cd_cyc[k][n_cd[k]] = cyc;
      if (compute_done[k]) n_cd[k]++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic snap(input int k);
    b_cs[k] = n_cs[k]; b_wr[k] = n_wr[k]; b_rd[k] = n_rd[k];
    b_pv[k] = n_pv[k]; b_ld[k] = n_ld[k]; b_cd[k] = n_cd[k];
  endtask

  function automatic logic [35:0] outv(input int k);
    return {cs[k], oe[k], addr[k], wr_en[k], wr_bank[k], wr_addr[k], wr_data[k],
            rd_en[k], rd_addr[k], pe_valid[k], load_done[k], compute_done[k], busy[k]};
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (outv(k) !== 36'h0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got %h expected 0", k, outv(k));
      end
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_ignored_idle;
    snap(0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (10) tick();
    checks++;
    if ((n_cs[0] - b_cs[0]) + (n_rd[0] - b_rd[0]) != 0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL start_in_idle: got cs=%0d rd=%0d busy=%b expected 0 0 0",
               n_cs[0] - b_cs[0], n_rd[0] - b_rd[0], busy[0]);
    end
  endtask

  task automatic test_reset_mid_load;
    snap(0);
    load[0] = 1'b1;
    tick();
    load[0] = 1'b0;
    repeat (19) tick();
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL midload_busy: got %b expected 1", busy[0]);
    end
    checks++;
    if (n_cs[0] - b_cs[0] != 19) begin
      errors++;
      $display("FAIL midload_requests: got %0d expected 19", n_cs[0] - b_cs[0]);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (outv(0) !== 36'h0) begin
      errors++;
      $display("FAIL midload_reset_outputs: got %h expected 0", outv(0));
    end
    snap(0);
    repeat (12) tick();
    checks++;
    if (n_cs[0] != b_cs[0] || n_wr[0] != b_wr[0] || n_ld[0] != b_ld[0] || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL midload_abandoned: got cs=%0d wr=%0d ld=%0d busy=%b expected 0 0 0 0",
               n_cs[0] - b_cs[0], n_wr[0] - b_wr[0], n_ld[0] - b_ld[0], busy[0]);
    end
  endtask

  task automatic test_load(input int k);
    int lag;
    int bad;
    int last;
    logic [7:0] sv [4][32];
    int sn [4][32];
    lag = (k == 0) ? 2 : 4;
    snap(k);
    load[k] = 1'b1;
    tick();
    load[k] = 1'b0;
    for (int i = 0; i < 600 && n_ld[k] == b_ld[k]; i++) tick();
    repeat (6) tick();
    checks++;
    if (n_ld[k] - b_ld[k] != 1) begin
      errors++;
      $display("FAIL load%0d_done_pulses: got %0d expected 1", k, n_ld[k] - b_ld[k]);
    end
    checks++;
    if (n_cs[k] - b_cs[k] != 81) begin
      errors++;
      $display("FAIL load%0d_request_count: got %0d expected 81", k, n_cs[k] - b_cs[k]);
    end
    bad = 0;
    for (int i = 0; i < 81; i++)
      if (cs_adr[k][b_cs[k]+i] !== {4'(i / 9), 4'(i % 9)} ||
          cs_cyc[k][b_cs[k]+i] != cs_cyc[k][b_cs[k]] + i) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL load%0d_request_order: got %0d bad requests expected 0", k, bad);
    end
    checks++;
    if (n_wr[k] - b_wr[k] != 81) begin
      errors++;
      $display("FAIL load%0d_write_count: got %0d expected 81", k, n_wr[k] - b_wr[k]);
    end
    bad = 0;
    for (int i = 0; i < 81; i++)
      if (wr_cyc[k][b_wr[k]+i] - cs_cyc[k][b_cs[k]+i] != lag) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL load%0d_write_lag: got %0d writes off lag expected 0 (lag %0d)", k, bad, lag);
    end
    checks++;
    if ({cs_adr[k][b_cs[k]+26], wr_bk[k][b_wr[k]+26], wr_ad[k][b_wr[k]+26], wr_dt[k][b_wr[k]+26]}
        !== {8'h28, 2'd0, 5'd8, 8'd26}) begin
      errors++;
      $display("FAIL load%0d_req_28: got adr=%h bank=%0d addr=%0d data=%0d expected 28 0 8 26", k,
               cs_adr[k][b_cs[k]+26], wr_bk[k][b_wr[k]+26], wr_ad[k][b_wr[k]+26], wr_dt[k][b_wr[k]+26]);
    end
    checks++;
    if ({cs_adr[k][b_cs[k]+5], wr_bk[k][b_wr[k]+5], wr_ad[k][b_wr[k]+5], wr_dt[k][b_wr[k]+5]}
        !== {8'h05, 2'd1, 5'd1, 8'd5}) begin
      errors++;
      $display("FAIL load%0d_req_05: got adr=%h bank=%0d addr=%0d data=%0d expected 05 1 1 5", k,
               cs_adr[k][b_cs[k]+5], wr_bk[k][b_wr[k]+5], wr_ad[k][b_wr[k]+5], wr_dt[k][b_wr[k]+5]);
    end
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 32; a++) begin
        sn[b][a] = 0;
        sv[b][a] = 8'h00;
      end
    for (int i = b_wr[k]; i < n_wr[k] && i < 1024; i++) begin
      sn[wr_bk[k][i]][wr_ad[k][i]]++;
      sv[wr_bk[k][i]][wr_ad[k][i]] = wr_dt[k][i];
    end
    bad = 0;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        if (sn[c % 4][r * 3 + c / 4] != 1 || sv[c % 4][r * 3 + c / 4] !== 8'(9 * r + c)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL load%0d_bank_contents: got %0d wrong slots expected 0", k, bad);
    end
    last = b_wr[k] + 80;
    checks++;
    if (ld_cyc[k][b_ld[k]] != wr_cyc[k][last] + 1) begin
      errors++;
      $display("FAIL load%0d_done_timing: got cycle %0d expected %0d", k, ld_cyc[k][b_ld[k]], wr_cyc[k][last] + 1);
    end
    checks++;
    if ({wr_busy[k][last], ld_busy[k][b_ld[k]], busy[k]} !== 3'b100) begin
      errors++;
      $display("FAIL load%0d_drain_busy: got %b expected 100", k,
               {wr_busy[k][last], ld_busy[k][b_ld[k]], busy[k]});
    end
  endtask

  task automatic test_compute;
    int sc;
    int bad;
    for (int pass = 0; pass < 2; pass++) begin
      snap(0);
      sc = cyc;
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      for (int i = 0; i < 100 && n_cd[0] == b_cd[0]; i++) tick();
      repeat (4) tick();
      checks++;
      if (n_cd[0] - b_cd[0] != 1) begin
        errors++;
        $display("FAIL compute%0d_done_pulses: got %0d expected 1", pass, n_cd[0] - b_cd[0]);
      end
      checks++;
      if (n_rd[0] - b_rd[0] != 27 || n_pv[0] - b_pv[0] != 27) begin
        errors++;
        $display("FAIL compute%0d_counts: got rd=%0d pv=%0d expected 27 27", pass,
                 n_rd[0] - b_rd[0], n_pv[0] - b_pv[0]);
      end
      bad = 0;
      for (int i = 0; i < 27; i++)
        if (rd_ad[0][b_rd[0]+i] !== 5'(i) || rd_cyc[0][b_rd[0]+i] != sc + 1 + i) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL compute%0d_rd_sequence: got %0d bad reads expected 0", pass, bad);
      end
      bad = 0;
      for (int i = 0; i < 27; i++)
        if (pv_cyc[0][b_pv[0]+i] != rd_cyc[0][b_rd[0]+i] + 1) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL compute%0d_pe_valid_delay: got %0d misaligned expected 0", pass, bad);
      end
      checks++;
      if (cd_cyc[0][b_cd[0]] != pv_cyc[0][b_pv[0]+26]) begin
        errors++;
        $display("FAIL compute%0d_done_timing: got cycle %0d expected %0d", pass,
                 cd_cyc[0][b_cd[0]], pv_cyc[0][b_pv[0]+26]);
      end
      checks++;
      if (n_cs[0] != b_cs[0] || n_wr[0] != b_wr[0] || busy[0] !== 1'b0) begin
        errors++;
        $display("FAIL compute%0d_quiet: got cs=%0d wr=%0d busy=%b expected 0 0 0", pass,
                 n_cs[0] - b_cs[0], n_wr[0] - b_wr[0], busy[0]);
      end
    end
  endtask

  task automatic test_ignored_requests;
    // load and load+start during LOAD
    snap(0);
    load[0] = 1'b1;
    tick();
    load[0] = 1'b0;
    repeat (10) tick();
    load[0] = 1'b1;
    start[0] = 1'b1;
    tick();
    load[0] = 1'b0;
    start[0] = 1'b0;
    for (int i = 0; i < 300 && n_ld[0] == b_ld[0]; i++) tick();
    repeat (5) tick();
    checks++;
    if (n_cs[0] - b_cs[0] != 81 || cs_cyc[0][b_cs[0]+80] - cs_cyc[0][b_cs[0]] != 80) begin
      errors++;
      $display("FAIL load_during_load: got %0d requests expected 81 contiguous", n_cs[0] - b_cs[0]);
    end
    checks++;
    if (n_rd[0] != b_rd[0] || n_ld[0] - b_ld[0] != 1) begin
      errors++;
      $display("FAIL load_during_load_side: got rd=%0d ld=%0d expected 0 1", n_rd[0] - b_rd[0], n_ld[0] - b_ld[0]);
    end
    // load during RUN
    snap(0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (10) tick();
    load[0] = 1'b1;
    tick();
    load[0] = 1'b0;
    for (int i = 0; i < 100 && n_cd[0] == b_cd[0]; i++) tick();
    repeat (5) tick();
    checks++;
    if (n_rd[0] - b_rd[0] != 27 || n_cs[0] != b_cs[0] || n_cd[0] - b_cd[0] != 1) begin
      errors++;
      $display("FAIL load_during_run: got rd=%0d cs=%0d cd=%0d expected 27 0 1",
               n_rd[0] - b_rd[0], n_cs[0] - b_cs[0], n_cd[0] - b_cd[0]);
    end
    // load+start together in LOADED
    snap(0);
    load[0] = 1'b1;
    start[0] = 1'b1;
    tick();
    load[0] = 1'b0;
    start[0] = 1'b0;
    for (int i = 0; i < 300 && n_ld[0] == b_ld[0]; i++) tick();
    repeat (5) tick();
    checks++;
    if (n_cs[0] - b_cs[0] != 81 || n_ld[0] - b_ld[0] != 1) begin
      errors++;
      $display("FAIL load_start_reload: got cs=%0d ld=%0d expected 81 1", n_cs[0] - b_cs[0], n_ld[0] - b_ld[0]);
    end
    checks++;
    if (n_rd[0] != b_rd[0]) begin
      errors++;
      $display("FAIL load_start_no_read: got rd=%0d expected 0", n_rd[0] - b_rd[0]);
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      load[k]  = 1'b0;
      start[k] = 1'b0;
    end
    test_reset();
    test_ignored_idle();
    test_reset_mid_load();
    test_load(0);
    test_load(1);
    test_compute();
    test_ignored_requests();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
